// File: rtl/alu_flag_stage.sv
// alu_flag_stage: execute-stage register and NZCV flag unit that sits behind
// the 32-bit adder. It registers the sum for writeback over a valid/ready
// handshake, evaluates the ARM condition code against the committed flags,
// and updates NZCV for flag-setting instructions.
//
// Optional feature macro: COND_EXEC_EN
//   defined   : full ARM condition evaluation; flags update only on pass.
//   undefined : cond is ignored, every entry passes, no decoder is built.
module alu_flag_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] result_in,
  input  logic        c_in,
  input  logic        v_in,
  input  logic        set_flags,
  input  logic [3:0]  cond,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result_out,
  output logic        cond_pass_out,
  output logic [3:0]  nzcv
);

  // Pipeline register and committed-flag state.
  logic        out_valid_q, out_valid_d;
  logic [31:0] result_q,    result_d;
  logic        cond_pass_q, cond_pass_d;
  logic [3:0]  nzcv_q,      nzcv_d;

  logic accept;
  logic pass;
  logic flag_we;

  // Handshake: the slot is free when empty or being drained this cycle.
  always_comb begin
    in_ready = !reset && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
  end

`ifdef COND_EXEC_EN
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  logic flag_n, flag_z, flag_c, flag_v;
  assign {flag_n, flag_z, flag_c, flag_v} = nzcv_q;

  // Condition decoder against the flags left by all earlier instructions.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path can leave it unassigned and infer a latch.
    pass = 1'b0;
    unique case (cond_e'(cond))
      COND_EQ: pass = flag_z;
      COND_NE: pass = !flag_z;
      COND_CS: pass = flag_c;
      COND_CC: pass = !flag_c;
      COND_MI: pass = flag_n;
      COND_PL: pass = !flag_n;
      COND_VS: pass = flag_v;
      COND_VC: pass = !flag_v;
      COND_HI: pass = flag_c && !flag_z;
      COND_LS: pass = !flag_c || flag_z;
      COND_GE: pass = (flag_n == flag_v);
      COND_LT: pass = (flag_n != flag_v);
      COND_GT: pass = !flag_z && (flag_n == flag_v);
      COND_LE: pass = flag_z || (flag_n != flag_v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
`else
  // Without conditional execution every instruction passes unconditionally.
  logic unused_cond;
  assign unused_cond = ^cond;
  assign pass        = 1'b1;
`endif

  // Next-state: capture on accept, retire on consume, flags on passing S-ops.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    cond_pass_d = cond_pass_q;
    nzcv_d      = nzcv_q;
    flag_we     = accept && pass && set_flags;

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = result_in;
      cond_pass_d = pass;
    end else if (out_ready) begin
      // Entry consumed with nothing behind it; data fields keep stale values.
      out_valid_d = 1'b0;
    end

    if (flag_we) begin
      nzcv_d = {result_in[31], (result_in == 32'h0), c_in, v_in};
    end
  end

  // State register with synchronous reset that dominates everything else.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too because the reset values of
    // result_out and cond_pass_out are architecturally visible.
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= 32'h0;
      cond_pass_q <= 1'b0;
      nzcv_q      <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments so all state updates see the same
      // pre-edge values, independent of statement order.
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cond_pass_q <= cond_pass_d;
      nzcv_q      <= nzcv_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign result_out    = result_q;
  assign cond_pass_out = cond_pass_q;
  assign nzcv          = nzcv_q;

endmodule
